// File: rtl/updown_counter_param.sv
// Parameterised up/down counter with clamped load, preset-to-MAX, terminal-count flag and wrap pulse.
// Define UDC_SATURATE_EN to saturate at 0/MAX instead of wrapping modulo MAX+1.
module updown_counter_param #(
    parameter int unsigned      WIDTH = 8,
    parameter logic [WIDTH-1:0] MAX   = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             preset,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

`ifdef UDC_SATURATE_EN
    localparam logic [WIDTH-1:0] UP_LIMIT_NEXT   = MAX;
    localparam logic [WIDTH-1:0] DOWN_LIMIT_NEXT = '0;
`else
    localparam logic [WIDTH-1:0] UP_LIMIT_NEXT   = '0;
    localparam logic [WIDTH-1:0] DOWN_LIMIT_NEXT = MAX;
`endif

    logic [WIDTH-1:0] count_reg, count_next;
    logic [WIDTH-1:0] load_clamped;
    logic             wrap_reg, wrap_next;
    logic             at_top, at_bottom;

    assign at_top       = (count_reg == MAX);
    assign at_bottom    = (count_reg == '0);
    assign tc           = en & ((mode & at_top) | (~mode & at_bottom));
    assign load_clamped = (load_val > MAX) ? MAX : load_val;

    // A boundary event is exactly an enabled count edge with tc high; load and preset suppress it.
    always_comb begin
        count_next = count_reg;
        wrap_next  = 1'b0;
        if (load) begin
            count_next = load_clamped;
        end else if (preset) begin
            count_next = MAX;
        end else if (en) begin
            wrap_next = tc;
            if (mode) begin
                count_next = at_top ? UP_LIMIT_NEXT : count_reg + ONE;
            end else begin
                count_next = at_bottom ? DOWN_LIMIT_NEXT : count_reg - ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_reg <= '0;
            wrap_reg  <= 1'b0;
        end else begin
            count_reg <= count_next;
            wrap_reg  <= wrap_next;
        end
    end

    assign count = count_reg;
    assign wrap  = wrap_reg;

endmodule

// File: tb/tb_updown_counter_param.sv
// Bench for updown_counter_param (WIDTH=5, MAX=23): directed boundary cases then random traffic,
// compared against an arithmetic reference model of the counting rules.
module tb_updown_counter_param;

    localparam int WIDTH = 5;
    localparam int MAXV  = 23;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             en = 1'b0;
    logic             mode = 1'b0;
    logic             load = 1'b0;
    logic [WIDTH-1:0] load_val = '0;
    logic             preset = 1'b0;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             wrap;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    // Reference state
    int model_count = 0;
    int model_wrap  = 0;

    updown_counter_param #(
        .WIDTH (WIDTH),
        .MAX   (5'(MAXV))
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .mode     (mode),
        .load     (load),
        .load_val (load_val),
        .preset   (preset),
        .count    (count),
        .tc       (tc),
        .wrap     (wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int observed, input int expected);
        compared++;
        if (observed != expected) begin
            mismatched++;
            $display("FAIL %s (cycle %0d): observed %0d expected %0d", tag, cyc, observed, expected);
        end
    endtask

    // One clock: drive inputs at the falling edge, check tc, advance the model, check registered outputs.
    task automatic cycle(input logic rst_n, input logic ld, input int lv,
                         input logic pr, input logic e, input logic m);
        int exp_tc;
        reset    = rst_n;
        load     = ld;
        load_val = 5'(lv);
        preset   = pr;
        en       = e;
        mode     = m;
        #1;
        exp_tc = (e && ((m && model_count == MAXV) || (!m && model_count == 0))) ? 1 : 0;
        check("tc", int'(tc), exp_tc);

        if (!rst_n) begin
            model_count = 0;
            model_wrap  = 0;
        end else if (ld) begin
            model_count = (lv > MAXV) ? MAXV : lv;
            model_wrap  = 0;
        end else if (pr) begin
            model_count = MAXV;
            model_wrap  = 0;
        end else if (e) begin
            model_wrap = exp_tc;
`ifdef UDC_SATURATE_EN
            if (m) model_count = (model_count + 1 > MAXV) ? MAXV : model_count + 1;
            else   model_count = (model_count - 1 < 0) ? 0 : model_count - 1;
`else
            if (m) model_count = (model_count + 1) % (MAXV + 1);
            else   model_count = (model_count + MAXV) % (MAXV + 1);
`endif
        end else begin
            model_wrap = 0;
        end

        @(posedge clk);
        #1;
        check("count", int'(count), model_count);
        check("wrap", int'(wrap), model_wrap);
        $display("cyc %0d rst=%b ld=%b lv=%0d pr=%b en=%b md=%b -> count=%0d wrap=%b tc=%b",
                 cyc, rst_n, ld, lv, pr, e, m, count, wrap, tc);
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);

        // Reset overrides load; then count up from zero
        cycle(1'b0, 1'b1, 9, 1'b0, 1'b0, 1'b0);
        check("reset_count_zero", int'(count), 0);
        repeat (3) cycle(1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b1);
        check("count_after_3_up", int'(count), 3);

        // Up boundary from preset
        cycle(1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b1);
        cycle(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b1);

        // Down boundary from zero
        cycle(1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);

        // Load clamp beats preset and a boundary count
        cycle(1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 30, 1'b1, 1'b1, 1'b1);
        check("clamp_count", int'(count), MAXV);
        cycle(1'b1, 1'b1, 7, 1'b1, 1'b1, 1'b1);
        check("load_7", int'(count), 7);

        // Approach MAX from 22, run past it, then reverse direction
        cycle(1'b1, 1'b1, 22, 1'b0, 1'b0, 1'b1);
        repeat (3) cycle(1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b1);
        cycle(1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0);

        // Mid-operation reset while counting down, then hold
        cycle(1'b1, 1'b1, 15, 1'b0, 1'b0, 1'b0);
        repeat (2) cycle(1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
        repeat (4) cycle(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        check("hold_after_reset", int'(count), 0);

        // Random traffic, biased toward enabled counting so boundaries are crossed often
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(31) != 0) ? 1'b1 : 1'b0,
                  ($urandom_range(7) == 0) ? 1'b1 : 1'b0,
                  int'($urandom_range(31)),
                  ($urandom_range(15) == 0) ? 1'b1 : 1'b0,
                  ($urandom_range(3) != 0) ? 1'b1 : 1'b0,
                  ($urandom_range(7) < 5) ? 1'b1 : 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
